// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage and a carry flop, LSB first.
// Operands are accepted and results returned through valid/ready handshakes.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  sh_a, sh_b;
  logic          c;
  logic [CW-1:0] cnt;
  logic          s, cn, last;

  always_comb begin
    s    = sh_a[0] ^ sh_b[0] ^ c;
    cn   = (sh_a[0] & sh_b[0]) | (sh_a[0] & c) | (sh_b[0] & c);
    last = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      sh_a        <= '0;
      sh_b        <= '0;
      c           <= 1'b0;
      cnt         <= '0;
      sum         <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          // Subtract is a + ~b + 1: invert B up front and seed the carry with 1.
          sh_a        <= a;
          sh_b        <= b ^ {W{sub}};
          c           <= sub;
          cnt         <= '0;
          start_ready <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          c    <= cn;
          sum  <= (sum >> 1) | (W'(s) << (W - 1));
          if (last) begin
            carry_out <= cn;
            overflow  <= c ^ cn;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (res_ready) begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed W=8 cases plus exhaustive W=1 and W=3.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {overflow, carry_out, sum} packed into 10 bits, sum right-aligned
  function automatic logic [9:0] model(input int w, input int x, input int y, input bit s);
    int mask, yy, t, sm, co, ov;
    mask = (1 << w) - 1;
    yy   = (y ^ (s ? mask : 0)) & mask;
    t    = x + yy + int'(s);
    sm   = t & mask;
    co   = (t >> w) & 1;
    ov   = (((sm ^ x ^ yy) >> (w - 1)) & 1) ^ co;
    return 10'((ov << 9) | (co << 8) | sm);
  endfunction

  logic [7:0] a8, b8, sum8;
  logic sub8, sv8, sr8, rv8, rr8, co8, ov8;
  logic [0:0] a1, b1, sum1;
  logic sub1, sv1, sr1, rv1, rr1, co1, ov1;
  logic [2:0] a3, b3, sum3;
  logic sub3, sv3, sr3, rv3, rr3, co3, ov3;

  logic [9:0] q8[$], q1[$], q3[$];

  serial_adder #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .sub(sub8), .res_valid(rv8), .res_ready(rr8), .sum(sum8),
    .carry_out(co8), .overflow(ov8));
  serial_adder #(.W(1)) u1 (.clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .sub(sub1), .res_valid(rv1), .res_ready(rr1), .sum(sum1),
    .carry_out(co1), .overflow(ov1));
  serial_adder #(.W(3)) u3 (.clk(clk), .rst_n(rst_n), .start_valid(sv3), .start_ready(sr3),
    .a(a3), .b(b3), .sub(sub3), .res_valid(rv3), .res_ready(rr3), .sum(sum3),
    .carry_out(co3), .overflow(ov3));

  always @(negedge clk) if (rst_n && rv8 && rr8) begin
    if (q8.size() == 0) check("unexp8", 1, 0);
    else check("res8", {22'd0, ov8, co8, sum8}, {22'd0, q8.pop_front()});
  end
  always @(negedge clk) if (rst_n && rv1 && rr1) begin
    if (q1.size() == 0) check("unexp1", 1, 0);
    else check("res1", {22'd0, ov1, co1, 7'd0, sum1}, {22'd0, q1.pop_front()});
  end
  always @(negedge clk) if (rst_n && rv3 && rr3) begin
    if (q3.size() == 0) check("unexp3", 1, 0);
    else check("res3", {22'd0, ov3, co3, 5'd0, sum3}, {22'd0, q3.pop_front()});
  end

  task automatic wait_sr8;
    int n = 0;
    @(negedge clk);
    while (!sr8 && n < 100) begin @(negedge clk); n++; end
    if (!sr8) check("sr8_timeout", {31'd0, sr8}, 1);
  endtask

  task automatic drain8;
    int n = 0;
    while (q8.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain8", q8.size(), 0);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [9:0] exp);
    wait_sr8();
    a8 = x; b8 = y; sub8 = s; sv8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1 sv8 = 1'b0;
    drain8();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    {a8, b8, sub8, sv8} = '0; rr8 = 1'b1;
    {a1, b1, sub1, sv1} = '0; rr1 = 1'b1;
    {a3, b3, sub3, sv3} = '0; rr3 = 1'b1;
    #12;
    check("rst_start_ready", {31'd0, sr8}, 1);
    check("rst_res_valid", {31'd0, rv8}, 0);
    check("rst_sum", {24'd0, sum8}, 0);
    check("rst_carry", {31'd0, co8}, 0);
    check("rst_ovf", {31'd0, ov8}, 0);
    @(negedge clk); rst_n = 1'b1;

    // basic add with latency check
    wait_sr8();
    a8 = 8'h2A; b8 = 8'h15; sub8 = 1'b0; sv8 = 1'b1;
    q8.push_back(10'h03F);
    @(posedge clk); #1 sv8 = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check(k < 8 ? "lat_low" : "lat_rise", {31'd0, rv8}, (k == 8) ? 1 : 0);
    end
    drain8();

    op8(8'hFF, 8'h01, 1'b0, 10'h100);
    op8(8'h7F, 8'h01, 1'b0, 10'h280);
    op8(8'h05, 8'h07, 1'b1, 10'h0FE);
    op8(8'h80, 8'h01, 1'b1, 10'h37F);

    // backpressure, inputs scrambled after acceptance, start_valid held high
    rr8 = 1'b0;
    wait_sr8();
    a8 = 8'h3C; b8 = 8'h19; sub8 = 1'b1; sv8 = 1'b1;
    q8.push_back(10'h123);
    @(posedge clk); #1;
    n = 0;
    while (!rv8 && n < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(negedge clk); n++;
    end
    check("bp_rise", {31'd0, rv8}, 1);
    for (int k = 0; k < 5; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(negedge clk);
      check("bp_hold", {22'd0, ov8, co8, sum8}, 32'h123);
      check("bp_start_ready", {31'd0, sr8}, 0);
      check("bp_res_valid", {31'd0, rv8}, 1);
    end
    @(posedge clk); #1 sv8 = 1'b0; rr8 = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_sr", {31'd0, sr8}, 1);
    check("bp_idle_rv", {31'd0, rv8}, 0);
    drain8();

    // reset mid-RUN, then a clean op must not see the stale carry
    wait_sr8();
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1 sv8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_res_valid", {31'd0, rv8}, 0);
    check("arst_start_ready", {31'd0, sr8}, 1);
    check("arst_sum", {24'd0, sum8}, 0);
    #2 rst_n = 1'b1;
    op8(8'h01, 8'h01, 1'b0, 10'h002);

    // exhaustive W=1 and W=3, back-to-back
    for (int x = 0; x < 2; x++) for (int y = 0; y < 2; y++) for (int s = 0; s < 2; s++) begin
      n = 0;
      @(negedge clk);
      while (!sr1 && n < 20) begin @(negedge clk); n++; end
      if (!sr1) check("sr1_timeout", {31'd0, sr1}, 1);
      a1 = 1'(x); b1 = 1'(y); sub1 = 1'(s); sv1 = 1'b1;
      q1.push_back(model(1, x, y, 1'(s)));
      @(posedge clk); #1 sv1 = 1'b0;
    end
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) for (int s = 0; s < 2; s++) begin
      n = 0;
      @(negedge clk);
      while (!sr3 && n < 20) begin @(negedge clk); n++; end
      if (!sr3) check("sr3_timeout", {31'd0, sr3}, 1);
      a3 = 3'(x); b3 = 3'(y); sub3 = 1'(s); sv3 = 1'b1;
      q3.push_back(model(3, x, y, 1'(s)));
      @(posedge clk); #1 sv3 = 1'b0;
    end
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 50) begin @(negedge clk); n++; end
    check("drain1", q1.size(), 0);
    check("drain3", q3.size(), 0);
    check("drain8_final", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
